iob_im_sprite: RTL and testbench
================================

IOB_IM_SPRITE -- requirements
Module: iob_im_sprite

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - N_OBJ, 4, number of objects (1..8).
  - COORD_W, 10, pixel coordinate width.
  - RGB_W, 12, colour width.
  - BG_RGB, 0, background colour.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, synchronous active-high reset.
  - obj_wr_en, in, 1, shadow write strobe.
  - obj_wr_idx, in, clog2(N_OBJ) (min 1), object index.
  - obj_wr_sel, in, 1, word select: 0 = LOC, 1 = ATTR.
  - obj_wr_data, in, 32, write data.
  - frame_start, in, 1, one-cycle pulse at the start of each frame.
  - pixel_valid, in, 1, pixel coordinate qualifier.
  - pixel_x, in, COORD_W, current pixel x.
  - pixel_y, in, COORD_W, current pixel y.
  - rgb_out, out, RGB_W, pixel colour.
  - rgb_valid, out, 1, rgb_out qualifier.
  - coll_status, out, N_OBJ, per-object collision flags for the previous frame.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 LOC word fields SHALL be:
  - [COORD_W-1:0] centre x.
  - [2*COORD_W-1:COORD_W] centre y.
  - bit 31 enable.
REQ-005 ATTR word fields SHALL be:
  - [5:0] half-width hw.
  - [11:6] half-height hh.
  - [12+RGB_W-1:12] colour.
REQ-006 A write with obj_wr_en=1 SHALL update only the shadow LOC or ATTR register of object obj_wr_idx; a write with obj_wr_idx >= N_OBJ SHALL be ignored.
REQ-007 On frame_start=1, all shadow registers SHALL be copied to the active set in one cycle.
REQ-008 A write coinciding with frame_start SHALL land in the shadow set only; the active set SHALL take the pre-write shadow value.
REQ-009 Rendering SHALL use only the active set, so objects never tear mid-frame.
REQ-010 Object i SHALL hit pixel (x,y) when it is enabled and cx-hw <= x <= cx+hw and cy-hh <= y <= cy+hh.
REQ-011 Hit comparisons SHALL use signed COORD_W+2-bit arithmetic, so there is no wrap-around: cx < hw SHALL clip at 0, and cx+hw beyond the coordinate range SHALL clip at the maximum coordinate.
REQ-012 Pipeline stage 1 SHALL register the per-object hit vector, pixel_valid and the object count popcount.
REQ-013 Pipeline stage 2 SHALL register rgb_out as the colour of the lowest-index hitting object, or BG_RGB if no object hits.
REQ-014 Latency SHALL be exactly 2 cycles, pixel_valid to rgb_valid, fully pipelined, one pixel per cycle.
REQ-015 When pixel_valid=0, stage 2 SHALL hold rgb_out at its last value with rgb_valid=0.
REQ-016 Collision accumulation: a collision accumulator SHALL OR in the stage-1 hit vector whenever 2 or more objects hit the same valid pixel.
REQ-017 On frame_start, coll_status SHALL load the accumulator and the accumulator SHALL clear.
REQ-018 A collision in the same cycle as frame_start SHALL count toward the new frame.
REQ-019 frame_start SHALL NOT flush the pipeline; in-flight pixels SHALL complete using the active set already sampled in stage 1.

Reset
REQ-020 On rst=1, all shadow and active registers SHALL clear, so every object is disabled.
REQ-021 On rst=1, the pipeline SHALL clear: rgb_out=BG_RGB, rgb_valid=0.
REQ-022 On rst=1, coll_status and the collision accumulator SHALL clear to 0.
REQ-023 Reset SHALL take priority over frame_start and obj_wr_en in the same cycle.
REQ-024 Reset asserted mid-frame SHALL discard in-flight pixels; no rgb_valid SHALL appear for pixels presented during or before the reset cycle.

Structure
REQ-025 Package iob_im_sprite_pkg SHALL hold the LOC/ATTR field offsets, the widths and the enable-bit position.
REQ-026 The per-object hit comparator SHALL be one sub-module, iob_im_sprite_hit, instantiated N_OBJ times.
REQ-027 Shadow, active and pipeline registers SHALL live in the top level.

Verification
REQ-028 Bench SHALL cover:
  - Single object: obj0 LOC x=100, y=50, en; ATTR hw=7, hh=7, colour 0xF00; frame_start; scan x=92..108 at y=50 -> rgb_out=0xF00 for x=93..107, BG elsewhere; each result 2 cycles after its input.
  - Edge clip: obj1 x=3, hw=7 -> pixels x=0..10 hit, with no hit at x=1020..1023.
  - Tear-free update: write obj0 x=200 mid-frame -> output unchanged until the next frame_start, then the object appears at x=200.
  - Priority/collision: obj0 colour 0x0F0 and obj2 colour 0x00F overlap at (300,300) -> rgb_out=0x0F0; after the next frame_start, coll_status=4'b0101.
  - Boundary writes: a write with obj_wr_idx=N_OBJ is ignored; a write coinciding with frame_start takes effect only at the following frame_start.
  - Reset: rst asserted mid-scan -> rgb_valid=0, rgb_out=BG_RGB and coll_status=0 the next cycle, with all objects disabled.

Source files
------------

// File: rtl/iob_im_sprite_pkg.sv
// ============================================================================
// Module   : iob_im_sprite_pkg
// Brief    : Field layout of the sprite LOC/ATTR words and shared helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_im_sprite_pkg;

  // Register word width seen on the write port
  localparam int WORD_W       = 32;

  // LOC word: {en, ..., cy, cx}; cy sits directly above cx
  localparam int LOC_X_LSB    = 0;
  localparam int LOC_EN_BIT   = 31;

  // ATTR word: {..., colour, hh, hw}
  localparam int ATTR_HALF_W  = 6;
  localparam int ATTR_HW_LSB  = 0;
  localparam int ATTR_HH_LSB  = 6;
  localparam int ATTR_COL_LSB = 12;

  // Width of the object hit counter (covers up to 8 objects)
  localparam int CNT_W        = 4;

  // LSB of the centre-y field, which follows the centre-x field
  function automatic int loc_y_lsb(input int coord_w);
    return LOC_X_LSB + coord_w;
  endfunction

  // Object index width, never narrower than one bit
  function automatic int idx_width(input int n_obj);
    return (n_obj > 1) ? $clog2(n_obj) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_im_sprite_hit.sv
// ============================================================================
// Module   : iob_im_sprite_hit
// Brief    : Rectangle hit test for one object against the current pixel.
//            Bounds are formed in two extra signed bits so that boxes which
//            straddle either end of the coordinate range clip cleanly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_im_sprite_hit
  import iob_im_sprite_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic                   en,
  input  logic [COORD_W-1:0]     cx,
  input  logic [COORD_W-1:0]     cy,
  input  logic [ATTR_HALF_W-1:0] hw,
  input  logic [ATTR_HALF_W-1:0] hh,
  input  logic [COORD_W-1:0]     px,
  input  logic [COORD_W-1:0]     py,
  output logic                   hit
);

  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] x_lo, x_hi, y_lo, y_hi, sx, sy;

  // Signed box bounds and inclusive containment test
  always_comb begin
    sx   = signed'({2'b00, px});
    sy   = signed'({2'b00, py});
    x_lo = signed'({2'b00, cx}) - signed'(SW'(hw));
    x_hi = signed'({2'b00, cx}) + signed'(SW'(hw));
    y_lo = signed'({2'b00, cy}) - signed'(SW'(hh));
    y_hi = signed'({2'b00, cy}) + signed'(SW'(hh));
    hit  = en && (sx >= x_lo) && (sx <= x_hi) && (sy >= y_lo) && (sy <= y_hi);
  end

endmodule

`default_nettype wire

// File: rtl/iob_im_sprite.sv
// ============================================================================
// Module   : iob_im_sprite
// Brief    : Multi-object sprite renderer. Software writes a shadow register
//            set which is copied to the active set at frame_start; a 2-stage
//            pipeline produces the colour of the lowest-index hitting object
//            and per-frame collision flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_im_sprite
  import iob_im_sprite_pkg::*;
#(
  parameter int               N_OBJ   = 4,
  parameter int               COORD_W = 10,
  parameter int               RGB_W   = 12,
  parameter logic [RGB_W-1:0] BG_RGB  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        obj_wr_en,
  input  logic [idx_width(N_OBJ)-1:0] obj_wr_idx,
  input  logic                        obj_wr_sel,
  input  logic [WORD_W-1:0]           obj_wr_data,
  input  logic                        frame_start,
  input  logic                        pixel_valid,
  input  logic [COORD_W-1:0]          pixel_x,
  input  logic [COORD_W-1:0]          pixel_y,
  output logic [RGB_W-1:0]            rgb_out,
  output logic                        rgb_valid,
  output logic [N_OBJ-1:0]            coll_status
);

  localparam int Y_LSB = loc_y_lsb(COORD_W);

  // Shadow (software-facing) and active (render-facing) object registers
  logic [WORD_W-1:0] loc_sh   [N_OBJ];
  logic [WORD_W-1:0] attr_sh  [N_OBJ];
  logic [WORD_W-1:0] loc_act  [N_OBJ];
  logic [WORD_W-1:0] attr_act [N_OBJ];

  // Combinational per-pixel results from the active set
  logic [N_OBJ-1:0]  hit_c;
  logic [RGB_W-1:0]  col_c    [N_OBJ];
  logic [CNT_W-1:0]  hit_cnt_c;

  // Stage-1 registers; colours are captured so a pixel already in flight
  // keeps the object set it was tested against across a frame_start
  logic              s1_valid;
  logic [N_OBJ-1:0]  s1_hit;
  logic [CNT_W-1:0]  s1_cnt;
  logic [RGB_W-1:0]  s1_col   [N_OBJ];

  logic [RGB_W-1:0]  sel_col;
  logic [N_OBJ-1:0]  coll_acc;
  logic              coll_hit;
  logic              wr_ok;

  // Indices beyond the populated object range are dropped
  assign wr_ok    = obj_wr_en && (int'({1'b0, obj_wr_idx}) < N_OBJ);
  assign coll_hit = s1_valid && (s1_cnt >= CNT_W'(2));

  // Shadow register writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        loc_sh[i]  <= '0;
        attr_sh[i] <= '0;
      end
    end else if (wr_ok) begin
      if (obj_wr_sel) attr_sh[obj_wr_idx] <= obj_wr_data;
      else            loc_sh[obj_wr_idx]  <= obj_wr_data;
    end
  end

  // Frame-synchronous copy; a coincident write is seen only at the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        loc_act[i]  <= '0;
        attr_act[i] <= '0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < N_OBJ; i++) begin
        loc_act[i]  <= loc_sh[i];
        attr_act[i] <= attr_sh[i];
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    // Bits of the register words that carry no field
    logic unused_bits;
    assign unused_bits = ^{loc_act[g][LOC_EN_BIT-1:Y_LSB+COORD_W],
                           attr_act[g][WORD_W-1:ATTR_COL_LSB+RGB_W]};

    assign col_c[g] = attr_act[g][ATTR_COL_LSB +: RGB_W];

    iob_im_sprite_hit #(
      .COORD_W (COORD_W)
    ) u_hit (
      .en  (loc_act[g][LOC_EN_BIT]),
      .cx  (loc_act[g][LOC_X_LSB +: COORD_W]),
      .cy  (loc_act[g][Y_LSB +: COORD_W]),
      .hw  (attr_act[g][ATTR_HW_LSB +: ATTR_HALF_W]),
      .hh  (attr_act[g][ATTR_HH_LSB +: ATTR_HALF_W]),
      .px  (pixel_x),
      .py  (pixel_y),
      .hit (hit_c[g])
    );
  end

  // Number of objects covering the current pixel
  always_comb begin
    hit_cnt_c = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_cnt_c = hit_cnt_c + CNT_W'(hit_c[i]);
    end
  end

  // Stage 1: hit vector, qualifier, count and colour snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_cnt   <= '0;
      for (int i = 0; i < N_OBJ; i++) s1_col[i] <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_hit   <= hit_c;
      s1_cnt   <= hit_cnt_c;
      for (int i = 0; i < N_OBJ; i++) s1_col[i] <= col_c[i];
    end
  end

  // Priority pick: scanning downward lets the lowest index win
  always_comb begin
    sel_col = BG_RGB;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_hit[i]) sel_col = s1_col[i];
    end
  end

  // Stage 2: colour output, held while no pixel is flowing
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out   <= BG_RGB;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s1_valid;
      if (s1_valid) rgb_out <= sel_col;
    end
  end

  // Collision accumulation; a collision on the frame_start cycle seeds the new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_acc    <= '0;
      coll_status <= '0;
    end else if (frame_start) begin
      coll_status <= coll_acc;
      coll_acc    <= coll_hit ? s1_hit : '0;
    end else if (coll_hit) begin
      coll_acc    <= coll_acc | s1_hit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_im_sprite.sv
// ============================================================================
// Module   : tb_iob_im_sprite
// Brief    : Scoreboard bench. dut4 is the default 4-object build; dut3 is a
//            3-object build sharing every input, so a write to index 3 is
//            out of range for dut3 only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_im_sprite;

  localparam logic [11:0] BG = 12'h0A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obj_wr_en = 1'b0;
  logic [1:0]  obj_wr_idx = '0;
  logic        obj_wr_sel = 1'b0;
  logic [31:0] obj_wr_data = '0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;

  logic [11:0] rgb4, rgb3;
  logic        vld4, vld3;
  logic [3:0]  coll4;
  logic [2:0]  coll3;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] e4;
    logic [11:0] e3;
    int          stamp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  iob_im_sprite #(
    .N_OBJ(4), .COORD_W(10), .RGB_W(12), .BG_RGB(BG)
  ) dut4 (
    .clk(clk), .rst(rst),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx), .obj_wr_sel(obj_wr_sel),
    .obj_wr_data(obj_wr_data), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rgb_out(rgb4), .rgb_valid(vld4), .coll_status(coll4)
  );

  iob_im_sprite #(
    .N_OBJ(3), .COORD_W(10), .RGB_W(12), .BG_RGB(BG)
  ) dut3 (
    .clk(clk), .rst(rst),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx), .obj_wr_sel(obj_wr_sel),
    .obj_wr_data(obj_wr_data), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rgb_out(rgb3), .rgb_valid(vld3), .coll_status(coll3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expectation per valid output
  always @(negedge clk) begin
    if (vld4) begin
      if (sb.size() == 0) begin
        check("unexpected_rgb_valid", 32'(vld4), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rgb_out_n4", 32'(rgb4), 32'(mon_e.e4));
        check("rgb_out_n3", 32'(rgb3), 32'(mon_e.e3));
        check("rgb_valid_n3", 32'(vld3), 32'd1);
        check("latency", 32'(cyc), 32'(mon_e.stamp));
      end
    end else if (vld3) begin
      check("rgb_valid_n3_only", 32'(vld3), 32'd0);
    end
  end

  function automatic logic [31:0] loc(input int x, input int y);
    return 32'h8000_0000 | (32'(y) << 10) | 32'(x);
  endfunction

  function automatic logic [31:0] attr(input int hw, input int hh, input logic [11:0] col);
    return (32'(col) << 12) | (32'(hh) << 6) | 32'(hw);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int idx, input logic sel, input logic [31:0] data, input logic fs);
    obj_wr_en   = 1'b1;
    obj_wr_idx  = 2'(idx);
    obj_wr_sel  = sel;
    obj_wr_data = data;
    frame_start = fs;
    step();
    obj_wr_en   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] e4, input logic [11:0] e3);
    exp_t e;
    pixel_valid = 1'b1;
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    e.e4 = e4; e.e3 = e3; e.stamp = cyc + 2;
    sb.push_back(e);
    step();
    pixel_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check("reset_rgb_valid", 32'(vld4), 32'd0);
    check("reset_rgb_out", 32'(rgb4), 32'(BG));
    check("reset_coll", 32'(coll4), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single object: centre 100,50, half 7 -> x 93..107
    wr(0, 1'b0, loc(100, 50), 1'b0);
    wr(0, 1'b1, attr(7, 7, 12'hF00), 1'b0);
    fs();
    for (int x = 92; x <= 108; x++)
      pix(x, 50, (x >= 93 && x <= 107) ? 12'hF00 : BG, (x >= 93 && x <= 107) ? 12'hF00 : BG);
    idle(4);

    // Left-edge clip: centre x=3, half 7 -> x 0..10; nothing wraps to 1020..1023
    wr(1, 1'b0, loc(3, 500), 1'b0);
    wr(1, 1'b1, attr(7, 7, 12'h123), 1'b0);
    fs();
    for (int x = 0; x <= 11; x++)
      pix(x, 500, (x <= 10) ? 12'h123 : BG, (x <= 10) ? 12'h123 : BG);
    for (int x = 1020; x <= 1023; x++)
      pix(x, 500, BG, BG);
    idle(4);

    // Tear-free move of obj0 to x=200
    pix(100, 50, 12'hF00, 12'hF00);
    pix(200, 50, BG, BG);
    wr(0, 1'b0, loc(200, 50), 1'b0);
    pix(100, 50, 12'hF00, 12'hF00);
    pix(200, 50, BG, BG);
    frame_start = 1'b1;
    pix(100, 50, 12'hF00, 12'hF00);   // sampled with the old active set
    frame_start = 1'b0;
    pix(100, 50, BG, BG);
    pix(200, 50, 12'hF00, 12'hF00);
    idle(4);

    // Boundary writes: idx 3 exists only in dut4; LOC write lands with frame_start
    wr(3, 1'b1, attr(2, 2, 12'h555), 1'b0);
    wr(3, 1'b0, loc(600, 600), 1'b1);
    pix(600, 600, BG, BG);
    fs();
    pix(600, 600, 12'h555, BG);
    pix(602, 602, 12'h555, BG);
    pix(603, 600, BG, BG);
    idle(4);

    // Priority and collision: obj0 and obj2 overlap at 300,300
    wr(0, 1'b0, loc(300, 300), 1'b0);
    wr(0, 1'b1, attr(4, 4, 12'h0F0), 1'b0);
    wr(2, 1'b0, loc(300, 300), 1'b0);
    wr(2, 1'b1, attr(4, 4, 12'h00F), 1'b0);
    fs();
    check("coll_no_overlap_n4", 32'(coll4), 32'd0);
    pix(300, 300, 12'h0F0, 12'h0F0);
    pix(304, 304, 12'h0F0, 12'h0F0);
    pix(305, 300, BG, BG);
    pix(296, 300, 12'h0F0, 12'h0F0);
    idle(3);
    fs();
    check("coll_status_n4", 32'(coll4), 32'b0101);
    check("coll_status_n3", 32'(coll3), 32'b101);
    idle(2);
    fs();
    check("coll_cleared_n4", 32'(coll4), 32'd0);
    pix(300, 300, 12'h0F0, 12'h0F0);
    idle(3);
    fs();
    check("coll_again_n4", 32'(coll4), 32'b0101);

    // Reset mid-scan, together with a write and a frame_start
    pix(301, 300, 12'h0F0, 12'h0F0);
    pix(302, 300, 12'h0F0, 12'h0F0);
    rst         = 1'b1;
    pixel_valid = 1'b1;
    pixel_x     = 10'd300;
    pixel_y     = 10'd300;
    obj_wr_en   = 1'b1;
    obj_wr_idx  = 2'd1;
    obj_wr_sel  = 1'b0;
    obj_wr_data = loc(300, 300);
    frame_start = 1'b1;
    while (sb.size() > 0 && sb[$].stamp > cyc) void'(sb.pop_back());
    step();
    rst         = 1'b0;
    pixel_valid = 1'b0;
    obj_wr_en   = 1'b0;
    frame_start = 1'b0;
    check("rst_rgb_valid", 32'(vld4), 32'd0);
    check("rst_rgb_out", 32'(rgb4), 32'(BG));
    check("rst_coll_n4", 32'(coll4), 32'd0);
    check("rst_coll_n3", 32'(coll3), 32'd0);
    idle(3);
    fs();
    pix(300, 300, BG, BG);
    pix(200, 50, BG, BG);
    pix(3, 500, BG, BG);
    pix(600, 600, BG, BG);
    idle(3);
    fs();
    check("post_rst_coll", 32'(coll4), 32'd0);

    idle(5);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
